// File: rtl/sys_pll_rst_ctrl.sv
// sys_pll_rst_ctrl: PLL reset sequencing and lock qualification.
// sys_rst is released only after a sustained, synchronized PLL lock.
module sys_pll_rst_ctrl #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int CNT_W               = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             sw_pll_rst_req,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic [1:0]       state_o,
  output logic             timeout_err,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int MAX_RS =
    (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
    PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_ALL =
    (MAX_RS > LOCK_TIMEOUT_CYCLES) ?
    MAX_RS : LOCK_TIMEOUT_CYCLES;
  // The counter only ever reaches (limit - 1) before a state change.
  localparam int CW = (MAX_ALL > 2) ? $clog2(MAX_ALL) : 1;

  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             lock_s;

  assign lock_s = sync2_q;

  always_comb begin
    sync1_d   = pll_locked;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    timeout_d = timeout_q;
    loss_d    = loss_q;

    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_PLL_RST;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d = S_PLL_RST;
          if (!(&loss_q)) loss_d = loss_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase

    // A software request overrides everything, including a lock loss.
    if (sw_pll_rst_req) begin
      state_d = S_PLL_RST;
      cnt_d   = '0;
      loss_d  = loss_q;
    end

    pll_rst_d = (state_d == S_PLL_RST);
    sys_rst_d = (state_d != S_RUN);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= '0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      timeout_q <= 1'b0;
      loss_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      timeout_q <= timeout_d;
      loss_q    <= loss_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst       = sys_rst_q;
  assign state_o       = state_q;
  assign timeout_err   = timeout_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_sys_pll_rst_ctrl.sv
// tb_sys_pll_rst_ctrl: vector table, directed corner sequences and
// randomized lock/request traffic against a cycle-level reference model.
module tb_sys_pll_rst_ctrl;

  localparam int P  = 4;
  localparam int S  = 8;
  localparam int T  = 32;
  localparam int CW = 2;

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_locked = 1'b0;
  logic          sw_pll_rst_req = 1'b0;
  logic          pll_rst;
  logic          sys_rst;
  logic [1:0]    state_o;
  logic          timeout_err;
  logic [CW-1:0] lock_loss_cnt;

  int checks = 0;
  int failures = 0;

  sys_pll_rst_ctrl #(
    .PLL_RST_CYCLES     (P),
    .LOCK_STABLE_CYCLES (S),
    .LOCK_TIMEOUT_CYCLES(T),
    .CNT_W              (CW)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .sw_pll_rst_req(sw_pll_rst_req),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .state_o       (state_o),
    .timeout_err   (timeout_err),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #10 refclk = ~refclk;

  // Reference model: phase plus time spent in it, lock seen two edges late.
  int        m_ph = 0;
  int        m_age = 0;
  logic      m_to = 1'b0;
  logic [1:0] m_loss = 2'b00;
  logic      m_s0 = 1'b0;
  logic      m_s1 = 1'b0;

  function automatic void enter(input int ph);
    m_ph  = ph;
    m_age = 0;
  endfunction

  always @(posedge refclk) begin : model_b
    logic seen;
    seen = m_s1;
    if (rst) begin
      m_ph = 0; m_age = 0; m_to = 1'b0;
      m_loss = 2'b00; m_s0 = 1'b0; m_s1 = 1'b0;
    end else begin
      m_s1 = m_s0;
      m_s0 = pll_locked;
      m_age++;
      if (sw_pll_rst_req) enter(0);
      else begin
        case (m_ph)
          0: if (m_age >= P) enter(1);
          1: begin
            if (seen) enter(2);
            else if (m_age >= T) begin
              enter(0);
              m_to = 1'b1;
            end
          end
          2: begin
            if (!seen) enter(1);
            else if (m_age >= S) enter(3);
          end
          default: begin
            if (!seen) begin
              enter(0);
              if (m_loss != 2'b11) m_loss++;
            end
          end
        endcase
      end
    end
  end

  logic [6:0] dut_v;
  assign dut_v = {pll_rst, sys_rst, state_o, timeout_err, lock_loss_cnt};

  function automatic logic [6:0] model_v();
    return {m_ph == 0, m_ph != 3, 2'(m_ph), m_to, m_loss};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic lk, input logic sw);
    rst = r;
    pll_locked = lk;
    sw_pll_rst_req = sw;
    @(posedge refclk);
    @(negedge refclk);
    chk("model", 32'(dut_v), 32'(model_v()));
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic rise_count(output int n);
    cyc(1'b0, 1'b1, 1'b0);
    n = 0;
    while (sys_rst !== 1'b0 && n < 100) begin
      cyc(1'b0, 1'b1, 1'b0);
      n++;
    end
  endtask

  task automatic until_state(input logic [1:0] st, input logic lk,
                             input string name);
    int n;
    n = 0;
    while (state_o !== st && n < 150) begin
      cyc(1'b0, lk, 1'b0);
      n++;
    end
    chk(name, 32'(state_o), 32'(st));
  endtask

  task automatic lose(output int n);
    n = 0;
    do begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end while (sys_rst !== 1'b1 && n < 10);
  endtask

  task automatic bringup();
    int n;
    n = 0;
    do begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end while (pll_rst === 1'b1 && n < 50);
    chk("pll_rst_hold", 32'(n), 32'(P));
    while (n < 10) begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    rise_count(n);
    chk("release_latency", 32'(n), 32'(S + 2));
    chk("run_state", 32'(state_o), 32'd3);
  endtask

  typedef struct {
    logic       r;
    logic       lk;
    int         n;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int n;
    int run_left;
    logic lk;
    logic [1:0] saved;

    // {pll_rst, sys_rst, state, timeout_err, lock_loss_cnt}
    vecs[0]  = '{1'b1, 1'b0, 2,  7'b1100000};
    vecs[1]  = '{1'b0, 1'b0, 3,  7'b1100000};
    vecs[2]  = '{1'b0, 1'b0, 1,  7'b0101000};
    vecs[3]  = '{1'b0, 1'b0, 6,  7'b0101000};
    vecs[4]  = '{1'b0, 1'b1, 2,  7'b0101000};
    vecs[5]  = '{1'b0, 1'b1, 1,  7'b0110000};
    vecs[6]  = '{1'b0, 1'b1, 7,  7'b0110000};
    vecs[7]  = '{1'b0, 1'b1, 1,  7'b0011000};
    vecs[8]  = '{1'b0, 1'b0, 2,  7'b0011000};
    vecs[9]  = '{1'b0, 1'b0, 1,  7'b1100001};
    vecs[10] = '{1'b0, 1'b0, 4,  7'b0101001};
    vecs[11] = '{1'b0, 1'b0, 31, 7'b0101001};
    vecs[12] = '{1'b0, 1'b0, 1,  7'b1100101};
    vecs[13] = '{1'b0, 1'b0, 4,  7'b0101101};
    vecs[14] = '{1'b0, 1'b0, 32, 7'b1100101};

    for (int i = 0; i < 15; i++) begin
      for (int j = 0; j < vecs[i].n; j++)
        cyc(vecs[i].r, vecs[i].lk, 1'b0);
      chk($sformatf("vec%0d", i), 32'(dut_v), 32'(vecs[i].exp));
    end

    // Lock chatter inside STABLE.
    do_reset();
    repeat (P) cyc(1'b0, 1'b0, 1'b0);
    repeat (7) cyc(1'b0, 1'b1, 1'b0);
    chk("chatter_in_stable", 32'(state_o), 32'd2);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("chatter_back_wait", 32'(state_o), 32'd1);
    chk("chatter_sys_rst", 32'(sys_rst), 32'd1);
    rise_count(n);
    chk("chatter_release", 32'(n), 32'(S + 2));
    chk("chatter_loss", 32'(lock_loss_cnt), 32'd0);

    // Repeated lock loss in RUN with saturation.
    do_reset();
    bringup();
    for (int i = 0; i < 4; i++) begin
      lose(n);
      chk("loss_latency", 32'(n), 32'd3);
      chk("loss_count", 32'(lock_loss_cnt), 32'((i < 3) ? i + 1 : 3));
      until_state(2'd3, 1'b1, "relock_run");
    end

    // Software request coinciding with a lock loss, then re-requested.
    do_reset();
    bringup();
    lose(n);
    until_state(2'd3, 1'b1, "sw_pre_run");
    saved = lock_loss_cnt;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("sw_state", 32'(state_o), 32'd0);
    chk("sw_loss_kept", 32'(lock_loss_cnt), 32'(saved));
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    n = 2;
    while (pll_rst === 1'b1 && n < 50) begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("sw_extend", 32'(n), 32'(2 + P));

    // Mid-operation reset from STABLE with sticky status set.
    do_reset();
    repeat (P + T) cyc(1'b0, 1'b0, 1'b0);
    chk("timeout_set", 32'(timeout_err), 32'd1);
    until_state(2'd3, 1'b1, "mid_run1");
    lose(n);
    until_state(2'd3, 1'b1, "mid_run2");
    lose(n);
    chk("mid_loss2", 32'(lock_loss_cnt), 32'd2);
    until_state(2'd2, 1'b1, "mid_stable");
    cyc(1'b1, 1'b1, 1'b0);
    chk("mid_reset_vals", 32'(dut_v), 32'b1100000);
    bringup();

    // Randomized traffic against the model.
    do_reset();
    lk = 1'b0;
    run_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        lk = ~lk;
        run_left = lk ? int'($urandom_range(1, 60))
                      : int'($urandom_range(1, 45));
      end
      run_left--;
      cyc(($urandom_range(0, 1499) == 0), lk,
          ($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sys_pll_rst_ctrl.md
# sys_pll_rst_ctrl

PLL reset and lock-qualification controller in the 50 MHz reference-clock domain. It drives the system PLL's reset input and consumes the PLL's `locked` output. It releases the design-wide `sys_rst` only after the PLL has held lock continuously for a programmable time. It re-runs the PLL reset sequence on lock loss, on lock timeout, or on a software request, and keeps sticky status for firmware.

## Interface
Parameters:
- `PLL_RST_CYCLES`, default 16: number of `refclk` cycles `pll_rst` is held high per reset attempt (≥2).
- `LOCK_STABLE_CYCLES`, default 1024: number of consecutive synchronized-locked cycles required before `sys_rst` is released (≥2).
- `LOCK_TIMEOUT_CYCLES`, default 65536: maximum cycles spent waiting for lock before the PLL reset is retried (≥2).
- `CNT_W`, default 8: width of the lock-loss counter.

Ports:
- `refclk`, input, 1 bit: the only clock (50 MHz board reference).
- `rst`, input, 1 bit: synchronous, active-high reset.
- `pll_locked`, input, 1 bit: PLL lock indicator. It is asynchronous to `refclk` and is synchronized internally.
- `sw_pll_rst_req`, input, 1 bit: single-cycle pulse that forces a new PLL reset sequence.
- `pll_rst`, output, 1 bit: reset to the PLL, active high, registered.
- `sys_rst`, output, 1 bit: system reset, active high, registered.
- `state_o`, output, 2 bits: current FSM state code (0 = PLL_RST, 1 = WAIT_LOCK, 2 = STABLE, 3 = RUN).
- `timeout_err`, output, 1 bit: sticky flag, set on any lock timeout.
- `lock_loss_cnt`, output, `CNT_W` bits: count of lock losses seen in RUN; saturates at all-ones.

## Operation
- **Synchronizer.** `pll_locked` passes through a 2-flop synchronizer; its output is `lock_s`. The FSM reads only `lock_s`.
- **Counter.** One shared cycle counter, wide enough for the largest parameter. It is cleared on every state entry.
- **PLL_RST.** `pll_rst`=1 and `sys_rst`=1.
  - After `PLL_RST_CYCLES` cycles in this state, go to WAIT_LOCK.
  - `lock_s` is ignored here.
- **WAIT_LOCK.** `pll_rst`=0 and `sys_rst`=1.
  - If `lock_s`=1, go to STABLE.
  - Otherwise, when the counter reaches `LOCK_TIMEOUT_CYCLES`-1, go to PLL_RST and set `timeout_err`.
- **STABLE.** `pll_rst`=0 and `sys_rst`=1.
  - If `lock_s`=0, go back to WAIT_LOCK. The counter clears and the timeout restarts; this is not a timeout error and not a lock loss.
  - After `LOCK_STABLE_CYCLES` consecutive cycles with `lock_s`=1, go to RUN.
- **RUN.** `pll_rst`=0 and `sys_rst`=0.
  - If `lock_s`=0, go to PLL_RST and increment `lock_loss_cnt` (saturating).
- **Software request.** `sw_pll_rst_req`=1 in any state forces PLL_RST with the counter cleared. It has priority over every other transition, including a simultaneous lock loss in RUN; in that case `lock_loss_cnt` does not increment. A request that arrives while already in PLL_RST restarts the full `PLL_RST_CYCLES` hold.
- **Sticky status.** `timeout_err` and `lock_loss_cnt` clear only on `rst`. They are not cleared by software requests or retries.
- **Register policy.** `pll_rst`, `sys_rst` and `state_o` are registered and update on the same edge as the state register. No combinational path exists from inputs to outputs.

## Timing
- **Reset values (while `rst`=1):** state = PLL_RST, `pll_rst`=1, `sys_rst`=1, `state_o`=0, `timeout_err`=0, `lock_loss_cnt`=0, counter=0, synchronizer flops=0.
- **Reset release.** `pll_rst` stays high for exactly `PLL_RST_CYCLES` edges after the first edge with `rst`=0, then falls.
- **Lock to WAIT_LOCK exit.** `pll_locked` rising is sampled at edge k. `lock_s`=1 after edge k+1. STABLE is entered at edge k+2.
- **Release latency.** `sys_rst` falls exactly `LOCK_STABLE_CYCLES` edges after STABLE entry, provided lock holds. Minimum latency from `pll_locked` rising to `sys_rst` falling is `LOCK_STABLE_CYCLES`+2 edges.
- **Lock-loss latency.** `pll_locked` falling sampled at edge k in RUN gives `sys_rst`=1 and `pll_rst`=1 after edge k+2.
- **Glitches.** A `pll_locked` glitch shorter than one cycle may be missed or captured; either outcome is legal.
- **Reset mid-operation.** Asserting `rst` in any state returns all outputs to their reset values on the next edge.

## Test plan
Bench parameters: `PLL_RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32, `CNT_W`=2.

1. **Nominal bring-up.** Release `rst`, raise `pll_locked` 10 cycles later and hold it → `pll_rst` high for 4 cycles. `sys_rst` falls 10 cycles after `pll_locked` rises; `state_o`=3.
2. **Lock timeout.** Keep `pll_locked`=0 → `timeout_err`=1 after 4+32 cycles, `pll_rst` re-asserts for 4 cycles, and this repeats every 36 cycles. `sys_rst` stays 1 throughout.
3. **Lock chatter in STABLE.** Drop `pll_locked` for 3 cycles after 5 locked cycles → returns to WAIT_LOCK. `sys_rst` is released only after 8 fresh consecutive locked cycles; `lock_loss_cnt`=0.
4. **Lock loss in RUN, repeated.** Cause 4 lock losses while in RUN → `sys_rst`=1 within 3 cycles of each loss. `lock_loss_cnt` reads 1, 2, 3, 3 (saturated).
5. **Software request with simultaneous lock loss.** Pulse `sw_pll_rst_req` on the same edge that `lock_s` falls in RUN → PLL_RST is entered and `lock_loss_cnt` is unchanged. A second request on the 2nd cycle of PLL_RST extends `pll_rst` to 2+4 cycles in total.
6. **Mid-operation reset.** Assert `rst` for 1 cycle in STABLE, with `timeout_err`=1 and `lock_loss_cnt`=2 → all outputs return to reset values on the next edge, and bring-up from scenario 1 repeats.
